// File: rtl/medfilt_pkg.sv
// ----------------------------------------------------------------------------
// medfilt_pkg
// Shared definitions for the median receiver: FSM state encoding, default
// widths and the window clamp helper.
// No ports (package).
// ----------------------------------------------------------------------------
package medfilt_pkg;

   localparam int DW_DEF    = 16;
   localparam int DEPTH_DEF = 8;
   localparam int CW_DEF    = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_INSERT = 2'd1,
      ST_OUTPUT = 2'd2
   } state_t;

   // Effective window size: 0 behaves as 1, anything above depth as depth.
   function automatic int eff_win(input int cfg, input int depth);
      if (cfg == 0)
         return 1;
      else if (cfg > depth)
         return depth;
      else
         return cfg;
   endfunction

endpackage

// File: rtl/medfilt_sortins.sv
// ----------------------------------------------------------------------------
// medfilt_sortins
// DEPTH-entry ascending sorted buffer with single-cycle insertion.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset (entries cleared)
//   ins_en    in   insert ins_data this cycle
//   ins_data  in   value to insert
//   count     in   number of occupied entries before the insert
//   buffer    out  all entries packed, entry i at [i*DW +: DW]
// ----------------------------------------------------------------------------
module medfilt_sortins
   import medfilt_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CW    = CW_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ins_en,
   input  logic [DW-1:0]         ins_data,
   input  logic [CW-1:0]         count,
   output logic [DEPTH*DW-1:0]   buffer
);

   logic [DW-1:0]    entry     [DEPTH];
   logic [DW-1:0]    entry_nxt [DEPTH];
   logic [DW-1:0]    prev      [DEPTH];
   logic [DEPTH-1:0] occupied;
   logic [DEPTH-1:0] greater;
   logic [DEPTH-1:0] shift_in;

   // Entries strictly greater than the new value move up one slot; equal
   // values stay put so the newcomer lands after them.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         occupied[i] = (CW'(i) < count);
         greater[i]  = (entry[i] > ins_data);
      end
      shift_in[0] = 1'b0;
      prev[0]     = ins_data;
      for (int i = 1; i < DEPTH; i++) begin
         shift_in[i] = occupied[i-1] & greater[i-1];
         prev[i]     = entry[i-1];
      end
      for (int i = 0; i < DEPTH; i++) begin
         entry_nxt[i] = entry[i];
         if ((occupied[i] && greater[i]) || (CW'(i) == count))
            entry_nxt[i] = shift_in[i] ? prev[i] : ins_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            entry[i] <= '0;
      end else if (ins_en) begin
         for (int i = 0; i < DEPTH; i++)
            entry[i] <= entry_nxt[i];
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++)
         buffer[i*DW +: DW] = entry[i];
   end

endmodule

// File: rtl/medfilt_rx.sv
// ----------------------------------------------------------------------------
// medfilt_rx
// Collects blocks of cfg_win measurements into a sorted buffer and emits the
// (lower) median of each block; blocks do not overlap.
// Ports:
//   clk                      in   system clock
//   rst_n                    in   asynchronous active-low reset
//   samplertop_medtop_start  in   one-cycle measurement strobe
//   samplertop_medtop_data   in   measurement, valid with strobe
//   ctrltop_medtop_clear     in   synchronous flush of block and overrun
//   cfg_win                  in   window size (0 -> 1, >DEPTH -> DEPTH)
//   medtop_ctrltop_valid     out  one-cycle median strobe
//   medtop_ctrltop_data      out  median, held until next valid
//   medtop_ctrltop_busy      out  high while not idle
//   medtop_ctrltop_overrun   out  sticky: a strobe arrived while busy
// ----------------------------------------------------------------------------
module medfilt_rx
   import medfilt_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CW    = CW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            samplertop_medtop_start,
   input  logic [DW-1:0]   samplertop_medtop_data,
   input  logic            ctrltop_medtop_clear,
   input  logic [CW-1:0]   cfg_win,
   output logic            medtop_ctrltop_valid,
   output logic [DW-1:0]   medtop_ctrltop_data,
   output logic            medtop_ctrltop_busy,
   output logic            medtop_ctrltop_overrun
);

   state_t              state;
   state_t              state_nxt;
   logic [DW-1:0]       hold;
   logic [CW-1:0]       count;
   logic [CW-1:0]       count_inc;
   logic [CW-1:0]       win_r;
   logic [CW-1:0]       win_eff;
   logic [CW-1:0]       mid;
   logic                overrun;
   logic [DW-1:0]       data_r;
   logic [DW-1:0]       median;
   logic                ins_en;
   logic [DEPTH*DW-1:0] buffer;

   assign win_eff   = CW'(eff_win(int'(cfg_win), DEPTH));
   assign count_inc = count + CW'(1);
   assign mid       = (win_r - CW'(1)) >> 1;
   assign ins_en    = (state == ST_INSERT) && !ctrltop_medtop_clear;

   medfilt_sortins #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_sortins (
      .clk      (clk),
      .rst_n    (rst_n),
      .ins_en   (ins_en),
      .ins_data (hold),
      .count    (count),
      .buffer   (buffer)
   );

   always_comb begin
      median = '0;
      for (int i = 0; i < DEPTH; i++)
         if (CW'(i) == mid)
            median = buffer[i*DW +: DW];
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      if (ctrltop_medtop_clear) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:   if (samplertop_medtop_start) state_nxt = ST_INSERT;
            ST_INSERT: state_nxt = (count_inc == win_r) ? ST_OUTPUT : ST_IDLE;
            ST_OUTPUT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
         endcase
      end
   end

   // Outputs: the median is presented straight from the buffer during OUTPUT
   // and latched into data_r so it holds afterwards.
   always_comb begin
      medtop_ctrltop_busy    = (state != ST_IDLE);
      medtop_ctrltop_valid   = (state == ST_OUTPUT) && !ctrltop_medtop_clear;
      medtop_ctrltop_data    = medtop_ctrltop_valid ? median : data_r;
      medtop_ctrltop_overrun = overrun;
   end

   // Datapath and flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold    <= '0;
         count   <= '0;
         win_r   <= '0;
         overrun <= 1'b0;
         data_r  <= '0;
      end else if (ctrltop_medtop_clear) begin
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (samplertop_medtop_start && (state != ST_IDLE))
            overrun <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (samplertop_medtop_start) begin
                  hold <= samplertop_medtop_data;
                  // Window is sampled only at the first sample of a block.
                  if (count == '0)
                     win_r <= win_eff;
               end
            end
            ST_INSERT: count <= count_inc;
            ST_OUTPUT: begin
               count  <= '0;
               data_r <= median;
            end
            default: ;
         endcase
      end
   end

endmodule
